am_err_monitor: RTL and testbench

Sequential error-statistics collector placed directly downstream of an unsigned 8x8 approximate multiplier. Each cycle it accepts one operand pair (x, y) with the multiplier's approximate product z. It computes the exact product and the error distance, then accumulates sample count, error count, signed error sum, absolute error sum, squared error sum and maximum absolute error over a programmable run of samples. It is used to score approximate-multiplier candidates in hardware (uniform or exhaustive stimulus) instead of in simulation-only scripts.

---
 rtl/am_metrics_pkg.sv | 51 +++++
 rtl/am_err_stage.sv | 75 +++++++
 rtl/am_err_monitor.sv | 178 +++++++++++++++++
 tb/tb_am_err_monitor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_metrics_pkg.sv
// am_metrics_pkg
// Shared definitions for the approximate-multiplier error monitor:
//   - datapath widths for operands, products, errors and accumulators
//   - run-control state enum
//   - sat_add: saturating add used by every counter and accumulator
package am_metrics_pkg;

    localparam int OP_W     = 8;
    localparam int PROD_W   = 16;
    localparam int ERR_W    = 17;
    localparam int SUMERR_W = 34;
    localparam int SUMABS_W = 32;
    localparam int SUMSQ_W  = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } am_state_e;

    // Adds two values already extended to 64 bits (sign-extended when
    // is_signed, zero-extended otherwise) and clamps the result to the
    // range of a w-bit signed or unsigned accumulator. The caller keeps
    // the low w bits of the result.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned w,
        input logic        is_signed
    );
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s = $signed({a[63], a}) + $signed({b[63], b});
        if (is_signed) begin
            hi = (65'sd1 <<< (w - 1)) - 65'sd1;
            lo = -(65'sd1 <<< (w - 1));
        end else begin
            hi = (65'sd1 <<< w) - 65'sd1;
            lo = '0;
        end
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/am_err_stage.sv
// am_err_stage
// Two-stage error pipeline behind the approximate multiplier.
//   S1: registers the exact product x*y, the approximate product and valid.
//   S2: registers signed error z-x*y, its magnitude and its square.
// Ports:
//   clk_i   clock
//   flush_i clears both valid bits (data registers are left free-running)
//   vld_i   sample accepted this cycle
//   x_i/y_i operands, z_i approximate product
//   vld_o   S2 valid; err_o (17b two's complement), abs_o (16b), sq_o (32b)
module am_err_stage
    import am_metrics_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  flush_i,
    input  logic                  vld_i,
    input  logic [OP_W-1:0]       x_i,
    input  logic [OP_W-1:0]       y_i,
    input  logic [PROD_W-1:0]     z_i,
    output logic                  vld_o,
    output logic [ERR_W-1:0]      err_o,
    output logic [PROD_W-1:0]     abs_o,
    output logic [2*PROD_W-1:0]   sq_o
);

    logic                      vld_p1;
    logic [PROD_W-1:0]         exact_p1;
    logic [PROD_W-1:0]         z_p1;

    logic signed [ERR_W-1:0]   err_s1;
    logic [PROD_W-1:0]         abs_s1;
    logic [2*PROD_W-1:0]       sq_s1;

    logic                      vld_p2;
    logic signed [ERR_W-1:0]   err_p2;
    logic [PROD_W-1:0]         abs_p2;
    logic [2*PROD_W-1:0]       sq_p2;

    // ---- stage S1: exact product ----
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_i;
        end
        exact_p1 <= PROD_W'(x_i) * PROD_W'(y_i);
        z_p1     <= z_i;
    end

    // Both products are 16-bit unsigned, so the difference always fits in
    // 17-bit signed and its magnitude never exceeds 65535.
    always_comb begin
        err_s1 = $signed({1'b0, z_p1}) - $signed({1'b0, exact_p1});
        abs_s1 = PROD_W'(err_s1[ERR_W-1] ? -err_s1 : err_s1);
        sq_s1  = (2*PROD_W)'(abs_s1) * (2*PROD_W)'(abs_s1);
    end

    // ---- stage S2: error, magnitude, square ----
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
        err_p2 <= err_s1;
        abs_p2 <= abs_s1;
        sq_p2  <= sq_s1;
    end

    assign vld_o = vld_p2;
    assign err_o = err_p2;
    assign abs_o = abs_p2;
    assign sq_o  = sq_p2;

endmodule

// File: rtl/am_err_monitor.sv
// am_err_monitor
// Collects error statistics of an 8x8 approximate multiplier over a run of
// NUM_SAMPLES accepted samples.
// Ports:
//   clk, rst (sync, active-high), clear (sync abort, same effect as rst)
//   start       begins a run from IDLE or DONE
//   in_valid/in_ready  sample handshake; in_ready is registered
//   x, y, z_approx     operands and approximate product
//   busy        run in progress (RUN or DRAIN), done: statistics final
//   sample_cnt, err_cnt, sum_err (signed), sum_abs_err, sum_sq_err,
//   max_abs_err  saturating statistics, valid two cycles after acceptance
module am_err_monitor
    import am_metrics_pkg::*;
#(
    parameter int NUM_SAMPLES = 65536,
    parameter int CNT_W       = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      x,
    input  logic [OP_W-1:0]      y,
    input  logic [PROD_W-1:0]    z_approx,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [SUMERR_W-1:0]  sum_err,
    output logic [SUMABS_W-1:0]  sum_abs_err,
    output logic [SUMSQ_W-1:0]   sum_sq_err,
    output logic [PROD_W-1:0]    max_abs_err
);

    localparam logic [CNT_W-1:0] N_C = CNT_W'(NUM_SAMPLES);

    am_state_e                  state_q, state_d;
    logic [CNT_W-1:0]           acc_q, acc_d;
    logic                       drain_q, drain_d;
    logic                       in_ready_q, in_ready_d;
    logic                       zero_stats;

    logic [CNT_W-1:0]           sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]           err_cnt_q, err_cnt_d;
    logic signed [SUMERR_W-1:0] sum_err_q, sum_err_d;
    logic [SUMABS_W-1:0]        sum_abs_q, sum_abs_d;
    logic [SUMSQ_W-1:0]         sum_sq_q, sum_sq_d;
    logic [PROD_W-1:0]          max_abs_q, max_abs_d;

    logic                       flush;
    logic                       accept;
    logic                       vld_p2;
    logic signed [ERR_W-1:0]    err_p2;
    logic [PROD_W-1:0]          abs_p2;
    logic [2*PROD_W-1:0]        sq_p2;

    assign flush  = rst | clear;
    assign accept = in_valid & in_ready_q;

    am_err_stage u_stage (
        .clk_i   (clk),
        .flush_i (flush),
        .vld_i   (accept),
        .x_i     (x),
        .y_i     (y),
        .z_i     (z_approx),
        .vld_o   (vld_p2),
        .err_o   (err_p2),
        .abs_o   (abs_p2),
        .sq_o    (sq_p2)
    );

    // Run control. RUN stays one extra cycle after the last acceptance with
    // in_ready low, then DRAIN holds two cycles so the last sample has been
    // accumulated well before done rises.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        drain_d    = drain_q;
        zero_stats = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    acc_d      = '0;
                    zero_stats = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_d = acc_q + 1'b1;
                end
                if (acc_q == N_C) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_RUN) && (acc_d < N_C);
    end

    // Accumulators. A start zeroes everything; otherwise each S2-valid
    // sample is folded in with saturation.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_err_d    = sum_err_q;
        sum_abs_d    = sum_abs_q;
        sum_sq_d     = sum_sq_q;
        max_abs_d    = max_abs_q;
        if (zero_stats) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sum_err_d    = '0;
            sum_abs_d    = '0;
            sum_sq_d     = '0;
            max_abs_d    = '0;
        end else if (vld_p2) begin
            sample_cnt_d = CNT_W'(sat_add(64'(sample_cnt_q), 64'd1, CNT_W, 1'b0));
            if (err_p2 != '0) begin
                err_cnt_d = CNT_W'(sat_add(64'(err_cnt_q), 64'd1, CNT_W, 1'b0));
            end
            sum_err_d = SUMERR_W'(sat_add(64'(sum_err_q), 64'(err_p2), SUMERR_W, 1'b1));
            sum_abs_d = SUMABS_W'(sat_add(64'(sum_abs_q), 64'(abs_p2), SUMABS_W, 1'b0));
            sum_sq_d  = SUMSQ_W'(sat_add(64'(sum_sq_q), 64'(sq_p2), SUMSQ_W, 1'b0));
            if (abs_p2 > max_abs_q) begin
                max_abs_d = abs_p2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            drain_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_err_q    <= '0;
            sum_abs_q    <= '0;
            sum_sq_q     <= '0;
            max_abs_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            drain_q      <= drain_d;
            in_ready_q   <= in_ready_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_err_q    <= sum_err_d;
            sum_abs_q    <= sum_abs_d;
            sum_sq_q     <= sum_sq_d;
            max_abs_q    <= max_abs_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign sample_cnt  = sample_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign sum_err     = sum_err_q;
    assign sum_abs_err = sum_abs_q;
    assign sum_sq_err  = sum_sq_q;
    assign max_abs_err = max_abs_q;

endmodule

// File: tb/tb_am_err_monitor.sv
// tb_am_err_monitor
// Four monitor instances share the sample bus: NUM_SAMPLES = 4, 1, 3 and
// 65536. Each has its own start. A per-sample scoreboard holds the expected
// running statistics for the instance under test; entries are pushed when a
// sample is accepted and popped when that instance's sample_cnt advances.
module tb_am_err_monitor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear, in_valid;
    logic [3:0]  start_a;
    logic [7:0]  x, y;
    logic [15:0] z;

    logic        in_ready_a [4];
    logic        busy_a     [4];
    logic        done_a     [4];
    logic [16:0] sample_cnt_a [4];
    logic [16:0] err_cnt_a    [4];
    logic [33:0] sum_err_a    [4];
    logic [31:0] sum_abs_a    [4];
    logic [47:0] sum_sq_a     [4];
    logic [15:0] max_a        [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        am_err_monitor #(
            .NUM_SAMPLES (g == 0 ? 4 : (g == 1 ? 1 : (g == 2 ? 3 : 65536))),
            .CNT_W       (17)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start_a[g]),
            .clear       (clear),
            .in_valid    (in_valid),
            .in_ready    (in_ready_a[g]),
            .x           (x),
            .y           (y),
            .z_approx    (z),
            .busy        (busy_a[g]),
            .done        (done_a[g]),
            .sample_cnt  (sample_cnt_a[g]),
            .err_cnt     (err_cnt_a[g]),
            .sum_err     (sum_err_a[g]),
            .sum_abs_err (sum_abs_a[g]),
            .sum_sq_err  (sum_sq_a[g]),
            .max_abs_err (max_a[g])
        );
    end

    typedef struct {
        longint se;
        longint sa;
        longint sq;
        int     mx;
        int     cnt;
        int     ec;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_vec = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     act = 0;
    int     last_cnt = 0;
    longint m_se, m_sa, m_sq;
    int     m_mx, m_cnt, m_ec;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_se = 0; m_sa = 0; m_sq = 0; m_mx = 0; m_cnt = 0; m_ec = 0;
        last_cnt = 0;
        sb.delete();
    endtask

    // One clock: account for an acceptance on the coming edge, then sample
    // outputs 1 time unit after the edge and retire scoreboard entries.
    task automatic step();
        bit     acc;
        int     ex, e, ae;
        exp_t   ent;
        acc = (in_valid === 1'b1) && (in_ready_a[act] === 1'b1) && !rst && !clear;
        if (acc) begin
            ex = int'(x) * int'(y);
            e  = int'(z) - ex;
            ae = (e < 0) ? -e : e;
            m_se += e;
            m_sa += ae;
            m_sq += longint'(ae) * longint'(ae);
            if (m_sq > 64'h0000_FFFF_FFFF_FFFF) m_sq = 64'h0000_FFFF_FFFF_FFFF;
            m_cnt++;
            if (e != 0) m_ec++;
            if (ae > m_mx) m_mx = ae;
            ent = '{se: m_se, sa: m_sa, sq: m_sq, mx: m_mx, cnt: m_cnt, ec: m_ec, cyc: cyc + 1};
            sb.push_back(ent);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (int'(sample_cnt_a[act]) > last_cnt) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_cnt", sample_cnt_a[act], last_cnt);
            end else begin
                ent = sb.pop_front();
                chk("sb_latency", cyc, ent.cyc + 2);
                chk("sb_sample_cnt", sample_cnt_a[act], ent.cnt);
                chk("sb_err_cnt", err_cnt_a[act], ent.ec);
                chk("sb_sum_err", $signed(sum_err_a[act]), ent.se);
                chk("sb_sum_abs", sum_abs_a[act], ent.sa);
                chk("sb_sum_sq", sum_sq_a[act], ent.sq);
                chk("sb_max_abs", max_a[act], ent.mx);
            end
            last_cnt = int'(sample_cnt_a[act]);
        end
    endtask

    task automatic check_stats(input string tag, input int k, input int cnt, input int ec,
                               input longint se, input longint sa, input longint sq,
                               input int mx);
        chk({tag, "_sample_cnt"}, sample_cnt_a[k], cnt);
        chk({tag, "_err_cnt"}, err_cnt_a[k], ec);
        chk({tag, "_sum_err"}, $signed(sum_err_a[k]), se);
        chk({tag, "_sum_abs"}, sum_abs_a[k], sa);
        chk({tag, "_sum_sq"}, sum_sq_a[k], sq);
        chk({tag, "_max_abs"}, max_a[k], mx);
    endtask

    task automatic check_idle(input string tag, input int k);
        chk({tag, "_in_ready"}, in_ready_a[k], 0);
        chk({tag, "_busy"}, busy_a[k], 0);
        chk({tag, "_done"}, done_a[k], 0);
        check_stats(tag, k, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic start_run(input int k);
        act = k;
        model_reset();
        start_a[k] = 1'b1;
        step();
        start_a[k] = 1'b0;
        chk("start_busy", busy_a[k], 1);
        chk("start_in_ready", in_ready_a[k], 1);
        chk("start_done", done_a[k], 0);
    endtask

    task automatic drive(input int xi, input int yi, input int zi, input logic v);
        x = 8'(xi);
        y = 8'(yi);
        z = 16'(zi);
        in_valid = v;
        step();
    endtask

    task automatic wait_done(input int k, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_a[k] === 1'b1) break;
            step();
        end
        chk("done_within_budget", done_a[k], 1);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; start_a = '0;
        x = '0; y = '0; z = '0;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) check_idle("reset", k);

        // Exact products, continuous valid, N=4
        start_run(0);
        drive(3, 5, 15, 1'b1);
        drive(255, 255, 65025, 1'b1);
        drive(0, 7, 0, 1'b1);
        drive(16, 16, 256, 1'b1);
        chk("last_acc_in_ready", in_ready_a[0], 0);
        chk("last_acc_busy", busy_a[0], 1);
        step();
        chk("t1_done", done_a[0], 0);
        chk("t1_busy", busy_a[0], 1);
        start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        chk("t2_done", done_a[0], 0);
        chk("t2_busy", busy_a[0], 1);
        step();
        chk("t3_done", done_a[0], 1);
        chk("t3_busy", busy_a[0], 0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("post_run_in_ready", in_ready_a[0], 0);
        end
        in_valid = 1'b0;
        chk("sb_empty_n4", sb.size(), 0);
        check_stats("n4_model", 0, m_cnt, m_ec, m_se, m_sa, m_sq, m_mx);
        check_stats("n4_const", 0, 4, 0, 0, 0, 0, 0);

        // Restart from DONE, then clear with samples in flight
        start_run(0);
        check_stats("restart", 0, 0, 0, 0, 0, 0, 0);
        drive(10, 10, 90, 1'b1);
        drive(20, 20, 410, 1'b1);
        drive(7, 7, 0, 1'b1);
        in_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        check_idle("clear", 0);
        step();
        check_idle("clear_next", 0);
        start_run(0);
        drive(1, 2, 3, 1'b1);
        drive(4, 4, 16, 1'b1);
        drive(9, 9, 80, 1'b1);
        drive(200, 100, 20001, 1'b1);
        in_valid = 1'b0;
        wait_done(0, 10);
        check_stats("post_clear_model", 0, m_cnt, m_ec, m_se, m_sa, m_sq, m_mx);
        check_stats("post_clear_const", 0, 4, 3, 1, 3, 3, 1);

        // Single worst-case sample, N=1
        start_run(1);
        drive(255, 255, 0, 1'b1);
        in_valid = 1'b0;
        wait_done(1, 10);
        check_stats("n1_const", 1, 1, 1, -65025, 65025, 64'd4228250625, 65025);

        // Valid toggling every cycle, N=3
        start_run(2);
        drive(2, 3, 8, 1'b1);
        drive(9, 9, 1, 1'b0);
        drive(2, 3, 4, 1'b1);
        drive(9, 9, 1, 1'b0);
        drive(1, 1, 1, 1'b1);
        in_valid = 1'b0;
        wait_done(2, 10);
        check_stats("n3_model", 2, m_cnt, m_ec, m_se, m_sa, m_sq, m_mx);
        check_stats("n3_const", 2, 3, 2, 0, 4, 8, 2);

        // Exhaustive sweep against a truncate-and-bias approximate multiplier
        start_run(3);
        for (int xi = 0; xi < 256; xi++) begin
            for (int yi = 0; yi < 256; yi++) begin
                drive(xi, yi, ((xi * yi) & 16'hFFF0) | 16'h0008, 1'b1);
            end
        end
        in_valid = 1'b0;
        wait_done(3, 20);
        chk("sb_empty_exh", sb.size(), 0);
        check_stats("exh_model", 3, m_cnt, m_ec, m_se, m_sa, m_sq, m_mx);
        chk("exh_sample_cnt", sample_cnt_a[3], 65536);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
